// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
//   Arbitrates the single register-file write port between the ALU and the
//   memory/load writeback sources. It also keeps a busy scoreboard of
//   destination registers that are still in flight, and generates the decode
//   stall for RAW and WAW hazards.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   alu_valid/rd/data      ALU writeback request; alu_ready = granted this cycle
//   mem_valid/rd/data      load writeback request; mem_ready = granted this cycle
//   issue_valid, issue_rd  decode issuing an instruction that writes issue_rd
//   rs1, rs2               decode source registers
//   stall                  decode must hold; the issue is not accepted
//   RegWrite, rd, WriteData registered register-file write port
module regfile_wb_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  stall,
  output logic                  RegWrite,
  output logic [ADDR_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0] WriteData
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic                  rr_mem_first;  // 0: ALU wins the next contested cycle
  logic [NREG-1:0]       busy;
  logic [NREG-1:0]       busy_next;
  logic                  grant_alu;
  logic                  grant_mem;
  logic                  grant_any;
  logic                  issue_accept;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  always_comb begin
    grant_alu = alu_valid & (~mem_valid | ~rr_mem_first);
    grant_mem = mem_valid & ~grant_alu;
  end

  assign grant_any = grant_alu | grant_mem;
  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;
  assign sel_rd    = grant_alu ? alu_rd   : mem_rd;
  assign sel_data  = grant_alu ? alu_data : mem_data;

  // The stall uses the busy bits before this edge's clear. A register that
  // commits at the coming edge would otherwise be read stale from the
  // register file's combinational read port.
  assign stall = ((rs1 != '0) & busy[rs1]) |
                 ((rs2 != '0) & busy[rs2]) |
                 (issue_valid & (issue_rd != '0) & busy[issue_rd]);

  assign issue_accept = issue_valid & ~stall & (issue_rd != '0);

  // The set is applied after the clear, so a new producer wins over a
  // same-edge commit of the old one.
  always_comb begin
    busy_next = busy;
    if (RegWrite)
      busy_next[rd] = 1'b0;
    if (issue_accept)
      busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite     <= 1'b0;
      rd           <= '0;
      WriteData    <= '0;
      busy         <= '0;
      rr_mem_first <= 1'b0;
    end else begin
      // Only contested cycles move the round-robin pointer.
      if (alu_valid & mem_valid)
        rr_mem_first <= ~rr_mem_first;
      // A grant to x0 is consumed without writing. rd and WriteData keep
      // their last values.
      RegWrite <= grant_any & (sel_rd != '0);
      if (grant_any & (sel_rd != '0)) begin
        rd        <= sel_rd;
        WriteData <= sel_data;
      end
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid, mem_valid, issue_valid;
  logic          alu_ready, mem_ready, stall;
  logic [AW-1:0] alu_rd, mem_rd, issue_rd, rs1, rs2, rd;
  logic [DW-1:0] alu_data, mem_data, WriteData;
  logic          RegWrite;

  int checks = 0;
  int failures = 0;

  // Behavioural reference state
  bit          m_busy[32];
  bit          m_mem_turn;      // 1: memory wins the next contested cycle
  bit          m_we;
  int unsigned m_rd;
  logic [DW-1:0] m_data;
  bit          e_alu, e_mem, e_stall;

  regfile_wb_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
    .stall(stall), .RegWrite(RegWrite), .rd(rd), .WriteData(WriteData)
  );

  always #5 clk = ~clk;

  task automatic model_eval();
    e_alu = 0;
    e_mem = 0;
    if (alu_valid && mem_valid) begin
      if (m_mem_turn) e_mem = 1; else e_alu = 1;
    end else if (alu_valid) e_alu = 1;
    else if (mem_valid) e_mem = 1;
    e_stall = 0;
    if (rs1 != 0 && m_busy[rs1]) e_stall = 1;
    if (rs2 != 0 && m_busy[rs2]) e_stall = 1;
    if (issue_valid && issue_rd != 0 && m_busy[issue_rd]) e_stall = 1;
  endtask

  // Advance one clock and update the reference model. Returns at posedge+1.
  task automatic tick();
    bit          wr;
    int unsigned wrd;
    logic [DW-1:0] wdata;
    model_eval();
    wr    = e_alu || e_mem;
    wrd   = e_alu ? alu_rd : mem_rd;
    wdata = e_alu ? alu_data : mem_data;
    @(posedge clk);
    if (reset) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_mem_turn = 0;
      m_we = 0;
      m_rd = 0;
      m_data = '0;
    end else begin
      if (m_we) m_busy[m_rd] = 0;
      if (issue_valid && !e_stall && issue_rd != 0) m_busy[issue_rd] = 1;
      if (alu_valid && mem_valid) m_mem_turn = !m_mem_turn;
      m_we = wr && (wrd != 0);
      if (m_we) begin
        m_rd = wrd;
        m_data = wdata;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; mem_valid = 0; issue_valid = 0;
    alu_rd = 0; mem_rd = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
    alu_data = '0; mem_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL reset_regwrite got=%b exp=0", RegWrite); end
    checks++; if (rd !== '0) begin failures++; $display("FAIL reset_rd got=%0d exp=0", rd); end
    checks++; if (WriteData !== '0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", WriteData); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
  endtask

  task automatic test_single_alu();
    alu_valid = 1; alu_rd = 3; alu_data = 32'h0000002A;
    #1;
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin failures++; $display("FAIL single_ready got=%b%b exp=10", alu_ready, mem_ready); end
    tick();
    alu_valid = 0;
    #1;
    checks++; if (RegWrite !== 1'b1 || rd !== 5'd3 || WriteData !== 32'h2A) begin failures++; $display("FAIL single_write got=%b/%0d/%h exp=1/3/0000002a", RegWrite, rd, WriteData); end
    tick();
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", RegWrite); end
  endtask

  task automatic test_back_to_back();
    bit exp_alu_seq[4] = '{1, 0, 1, 0};
    alu_valid = 1; alu_rd = 5; alu_data = 32'h11;
    mem_valid = 1; mem_rd = 6; mem_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (alu_ready !== exp_alu_seq[i] || mem_ready !== !exp_alu_seq[i]) begin failures++; $display("FAIL contest_grant%0d got=%b%b exp=%b%b", i, alu_ready, mem_ready, exp_alu_seq[i], !exp_alu_seq[i]); end
      if (i > 0) begin
        checks++; if (RegWrite !== 1'b1 || rd !== (exp_alu_seq[i-1] ? 5'd5 : 5'd6)) begin failures++; $display("FAIL contest_write%0d got=%b/%0d exp=1/%0d", i, RegWrite, rd, exp_alu_seq[i-1] ? 5 : 6); end
      end
      tick();
    end
    alu_valid = 0; mem_valid = 0;
    #1;
    checks++; if (RegWrite !== 1'b1 || rd !== 5'd6 || WriteData !== 32'h22) begin failures++; $display("FAIL contest_last got=%b/%0d/%h exp=1/6/00000022", RegWrite, rd, WriteData); end
    tick();
  endtask

  task automatic test_raw();
    issue_valid = 1; issue_rd = 7;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL raw_issue_stall got=%b exp=0", stall); end
    tick();
    issue_valid = 0; rs1 = 7;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL raw_stall got=%b exp=1", stall); end
    mem_valid = 1; mem_rd = 7; mem_data = 32'h77;
    #1;
    checks++; if (mem_ready !== 1'b1 || stall !== 1'b1) begin failures++; $display("FAIL raw_grant got=%b/%b exp=1/1", mem_ready, stall); end
    tick();
    mem_valid = 0;
    #1;
    checks++; if (RegWrite !== 1'b1 || rd !== 5'd7 || stall !== 1'b1) begin failures++; $display("FAIL raw_commit got=%b/%0d/%b exp=1/7/1", RegWrite, rd, stall); end
    tick();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL raw_release got=%b exp=0", stall); end
    rs1 = 0;
  endtask

  task automatic test_waw();
    issue_valid = 1; issue_rd = 9;
    tick();
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL waw_stall got=%b exp=1", stall); end
    alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
    tick();
    alu_valid = 0;
    #1;
    checks++; if (RegWrite !== 1'b1 || rd !== 5'd9 || stall !== 1'b1) begin failures++; $display("FAIL waw_commit got=%b/%0d/%b exp=1/9/1", RegWrite, rd, stall); end
    tick();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL waw_accept got=%b exp=0", stall); end
    tick();
    issue_valid = 0; rs1 = 9;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL waw_reset got=%b exp=1", stall); end
    rs1 = 0;
    alu_valid = 1; alu_rd = 9; alu_data = 32'h98;
    tick();
    alu_valid = 0;
    tick();
  endtask

  task automatic test_rd_zero();
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFFFFFF; rs1 = 0;
    #1;
    checks++; if (alu_ready !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL x0_ready got=%b/%b exp=1/0", alu_ready, stall); end
    tick();
    alu_valid = 0;
    #1;
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL x0_regwrite got=%b exp=0", RegWrite); end
    tick();
    checks++; if (RegWrite !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL x0_after got=%b/%b exp=0/0", RegWrite, stall); end
  endtask

  task automatic test_reset_mid();
    issue_valid = 1; issue_rd = 4;
    alu_valid = 1; alu_rd = 10; alu_data = 32'hA;
    mem_valid = 1; mem_rd = 11; mem_data = 32'hB;
    tick();
    issue_valid = 0;
    reset = 1;
    tick();
    reset = 0; rs1 = 4;
    #1;
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL midrst_regwrite got=%b exp=0", RegWrite); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", stall); end
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin failures++; $display("FAIL midrst_ptr got=%b%b exp=10", alu_ready, mem_ready); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      issue_valid = $urandom_range(0, 1);
      issue_rd = $urandom_range(0, 7);
      rs1 = $urandom_range(0, 7);
      rs2 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 0;
      #1;
      model_eval();
      checks++; if (alu_ready !== e_alu || mem_ready !== e_mem) begin failures++; $display("FAIL rand_grant c=%0d got=%b%b exp=%b%b", c, alu_ready, mem_ready, e_alu, e_mem); end
      checks++; if (stall !== e_stall) begin failures++; $display("FAIL rand_stall c=%0d got=%b exp=%b", c, stall, e_stall); end
      checks++; if (RegWrite !== m_we) begin failures++; $display("FAIL rand_regwrite c=%0d got=%b exp=%b", c, RegWrite, m_we); end
      if (m_we) begin
        checks++; if (rd !== m_rd[AW-1:0] || WriteData !== m_data) begin failures++; $display("FAIL rand_wport c=%0d got=%0d/%h exp=%0d/%h", c, rd, WriteData, m_rd, m_data); end
      end
      tick();
      // A source that was not granted keeps its request unchanged.
      if (!(alu_valid && !e_alu) || reset) begin
        alu_valid = $urandom_range(0, 1); alu_rd = $urandom_range(0, 7); alu_data = $urandom;
      end
      if (!(mem_valid && !e_mem) || reset) begin
        mem_valid = $urandom_range(0, 1); mem_rd = $urandom_range(0, 7); mem_data = $urandom;
      end
    end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    m_mem_turn = 0; m_we = 0; m_rd = 0; m_data = '0;
    foreach (m_busy[i]) m_busy[i] = 0;
    test_reset();
    test_single_alu();
    test_back_to_back();
    test_raw();
    test_waw();
    test_rd_zero();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Shares the register-file write port (RegWrite/rd/WriteData) between two writeback sources: ALU and memory/load unit.
- Tracks in-flight destination registers in a 32-entry busy scoreboard.
- Generates the decode-stage stall for RAW and WAW hazards.
- Sits between the execute/memory stages and the register file; its write outputs drive the register file directly.

Parameters:
- DATA_WIDTH, 32, writeback data width
- ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH registers; register 0 hardwired to zero)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- alu_valid  input  1  ALU writeback request
- alu_ready  output  1  ALU request accepted this cycle
- alu_rd  input  ADDR_WIDTH  ALU destination register
- alu_data  input  DATA_WIDTH  ALU result
- mem_valid  input  1  memory writeback request
- mem_ready  output  1  memory request accepted this cycle
- mem_rd  input  ADDR_WIDTH  memory destination register
- mem_data  input  DATA_WIDTH  load result
- issue_valid  input  1  decode issuing an instruction that writes issue_rd
- issue_rd  input  ADDR_WIDTH  destination of issuing instruction
- rs1  input  ADDR_WIDTH  decode source register 1
- rs2  input  ADDR_WIDTH  decode source register 2
- stall  output  1  decode must hold; issue not accepted
- RegWrite  output  1  register-file write enable (registered)
- rd  output  ADDR_WIDTH  register-file write index (registered)
- WriteData  output  DATA_WIDTH  register-file write data (registered)

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset:
  - RegWrite=0, rd=0, WriteData=0.
  - All busy bits cleared.
  - Round-robin pointer set to ALU-first.
  - Reset mid-transfer discards any pending write; RegWrite is 0 the cycle after reset is sampled.
- Arbitration (combinational ready):
  - Only one valid: that requester is granted.
  - Both valid: pointer selects the winner; pointer toggles to the other source after every contested grant; uncontested grants leave the pointer unchanged.
  - alu_ready / mem_ready high only for the granted source.
  - A requester not granted must hold valid/rd/data stable until ready.
- Write pipeline:
  - Granted request is registered at the edge: next cycle RegWrite=1, rd=req rd, WriteData=req data.
  - Latency is 1 cycle from acceptance to RegWrite.
  - Throughput is one write per cycle.
  - Granted request with rd=0 is accepted (ready=1), but RegWrite stays 0 and the scoreboard is unaffected.
  - No grant: RegWrite=0; rd and WriteData hold their last values.
- Scoreboard:
  - busy[r] set at an edge where issue_valid=1, stall=0, issue_rd=r, r!=0.
  - busy[r] cleared at an edge where RegWrite=1 and rd=r, i.e. the same edge the register file commits the value.
  - Set and clear of the same r at the same edge: set wins (new producer).
  - busy[0] always 0.
- Stall (combinational):
  - stall = (rs1!=0 & busy[rs1]) | (rs2!=0 & busy[rs2]) | (issue_valid & issue_rd!=0 & busy[issue_rd]).
  - While stall=1 the issue is ignored (no set).
  - Stall is evaluated before same-cycle clears: a register whose write commits at the coming edge still stalls this cycle. This prevents reading the stale value from the register file's combinational read port.
- No forwarding in this block; writebacks for registers not marked busy are still written normally.

Test Plan:
- Reset then alu_valid=1, alu_rd=3, alu_data=0x0000002A -> alu_ready=1 same cycle; next cycle RegWrite=1, rd=3, WriteData=0x2A; following cycle RegWrite=0.
- Both valid for 4 consecutive cycles (alu_rd=5/data=0x11, mem_rd=6/data=0x22), sources holding until ready -> grants ALU, MEM, ALU, MEM; RegWrite stays high each cycle after the first; pointer alternates.
- issue_valid=1, issue_rd=7 -> busy[7]; next cycle rs1=7 -> stall=1; mem writes rd=7 -> stall stays 1 through the RegWrite cycle, drops to 0 the cycle after.
- WAW check: busy[9] set, issue_valid=1, issue_rd=9, rs1=rs2=0 -> stall=1 and no re-set; after the writeback to 9 commits, the issue is accepted.
- alu_valid=1, alu_rd=0, data=0xFFFFFFFF -> alu_ready=1, RegWrite never asserts; stall with rs1=0 always 0.
- Assert reset for 1 cycle while both sources valid and busy[4]=1 -> next cycle RegWrite=0, busy cleared (rs1=4 gives stall=0), first post-reset contested grant goes to ALU.
